// File: rtl/muldiv_issue_ctrl.sv
// Issue/hazard control between EX and the shared HI/LO mul/div unit.
// Registers unit commands and stalls EX while a mul/div is in flight.
module muldiv_issue_ctrl #(
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10,
  parameter int CNT_W   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic [2:0]  op,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        flush,
  output logic        stall,
  output logic        md_start,
  output logic        md_we,
  output logic        md_hilo,
  output logic [1:0]  md_mulop,
  output logic [31:0] md_a,
  output logic [31:0] md_b,
  output logic        busy,
  output logic        div_zero
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE_MD,
    ISSUE_WR,
    RUN
  } state_t;

  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT);
  localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT);

  state_t           state;
  logic [CNT_W-1:0] cnt;

  logic live;
  logic accept;
  logic is_md;
  logic is_mt;
  logic is_dz;

  assign live   = op_valid & ~flush;
  assign stall  = live & (state != IDLE);
  assign accept = live & ~stall;
  assign busy   = (state != IDLE);

  assign is_md = ~op[2];
  assign is_mt = (op[2:1] == 2'b10);
  assign is_dz = is_md & op[1] & (op_b == '0);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      md_start <= 1'b0;
      md_we    <= 1'b0;
      md_hilo  <= 1'b0;
      md_mulop <= 2'b00;
      md_a     <= '0;
      md_b     <= '0;
      div_zero <= 1'b0;
    end else begin
      md_start <= 1'b0;
      md_we    <= 1'b0;
      div_zero <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            // mfhi/mflo fall through: EX reads HI/LO directly
            unique case (1'b1)
              is_md && !is_dz: begin
                state    <= ISSUE_MD;
                md_start <= 1'b1;
                md_mulop <= op[1:0];
                md_a     <= op_a;
                md_b     <= op_b;
              end
              is_dz: begin
                div_zero <= 1'b1;
              end
              is_mt: begin
                state   <= ISSUE_WR;
                md_we   <= 1'b1;
                md_hilo <= ~op[0];
                md_a    <= op_a;
              end
              default: begin
              end
            endcase
          end
        end
        ISSUE_MD: begin
          cnt   <= md_mulop[1] ? DIV_CNT : MUL_CNT;
          state <= RUN;
        end
        ISSUE_WR: begin
          state <= IDLE;
        end
        RUN: begin
          if (cnt <= 1) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
